// File: rtl/packetmem_handoff.sv
// rtl/packetmem_handoff.sv - packet buffer handing packets from snooper to BPF CPU and forwarder
// Even/odd word banks let an unaligned CPU read fetch both spanned words in one cycle.
module packetmem_handoff #(
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]           wr_data,
  input  logic                  wr_en,
  input  logic                  wr_done,
  input  logic [2:0]            wr_last_bytes,
  output logic                  snooper_rdy,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH+1:0] cpu_rd_addr,
  input  logic                  cpu_rd_en,
  input  logic [1:0]            transfer_sz,
  output logic [31:0]           cpu_rd_data,
  output logic [31:0]           packet_len,
  input  logic                  accept,
  input  logic                  reject,
  output logic                  cpu_rst,
  output logic                  filter_timeout,
  output logic                  fwd_valid,
  input  logic [ADDR_WIDTH-1:0] fwd_rd_addr,
  input  logic                  fwd_rd_en,
  output logic [31:0]           fwd_rd_data,
  input  logic                  fwd_done
);

  localparam int HALF = 2 ** (ADDR_WIDTH - 1);
  localparam int BW   = ADDR_WIDTH + 2;

  typedef enum logic [1:0] {FILL, FILTER, FORWARD} state_t;

  state_t      state, state_nxt;
  logic [31:0] wd_cnt;
  logic        timeout_hit;
  logic [2:0]  last_bytes;

  logic [31:0] bank_even [HALF];
  logic [31:0] bank_odd  [HALF];

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    snooper_rdy = 1'b0;
    mem_ready   = 1'b0;
    fwd_valid   = 1'b0;
    case (state)
      FILL: begin
        snooper_rdy = 1'b1;
        if (wr_en && wr_done) state_nxt = FILTER;
      end
      FILTER: begin
        mem_ready = 1'b1;
        if (reject) begin
          state_nxt = FILL;
        end else if (accept) begin
          state_nxt = FORWARD;
        end else if (TIMEOUT != 0 && wd_cnt == 32'(TIMEOUT - 1)) begin
          state_nxt   = FILL;
          timeout_hit = 1'b1;
        end
      end
      FORWARD: begin
        fwd_valid = 1'b1;
        if (fwd_done) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  assign last_bytes = (wr_last_bytes == 3'd0 || wr_last_bytes > 3'd4) ? 3'd4 : wr_last_bytes;

  // Watchdog runs only while the CPU owns the buffer; any other state clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt         <= '0;
      filter_timeout <= 1'b0;
      cpu_rst        <= 1'b0;
      packet_len     <= '0;
    end else begin
      wd_cnt         <= (state == FILTER) ? wd_cnt + 32'd1 : 32'd0;
      filter_timeout <= timeout_hit;
      cpu_rst        <= timeout_hit;
      if (state == FILL && wr_en && wr_done)
        packet_len <= 32'({wr_addr, 2'b00}) + 32'(last_bytes);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == FILL && wr_en) begin
      if (wr_addr[0]) bank_odd[wr_addr[ADDR_WIDTH-1:1]]  <= wr_data;
      else            bank_even[wr_addr[ADDR_WIDTH-1:1]] <= wr_data;
    end
  end

  logic [ADDR_WIDTH-1:0] w0, w1;
  logic [ADDR_WIDTH-2:0] ev_idx, od_idx;
  logic [31:0]           ev_word, od_word, rd_word;
  logic [63:0]           span;
  logic [7:0]            sel [4];
  logic [BW-1:0]         byte_idx;

  // span holds the addressed word followed by its successor, big-endian.
  always_comb begin
    w0       = cpu_rd_addr[BW-1:2];
    w1       = w0 + ADDR_WIDTH'(1);
    ev_idx   = w0[0] ? w1[ADDR_WIDTH-1:1] : w0[ADDR_WIDTH-1:1];
    od_idx   = w0[ADDR_WIDTH-1:1];
    ev_word  = bank_even[ev_idx];
    od_word  = bank_odd[od_idx];
    span     = w0[0] ? {od_word, ev_word} : {ev_word, od_word};
    byte_idx = '0;
    sel      = '{default: 8'h00};
    for (int i = 0; i < 4; i++) begin
      byte_idx = cpu_rd_addr + BW'(i);
      sel[i]   = span[8 * (7 - (int'(cpu_rd_addr[1:0]) + i)) +: 8];
      if (32'(byte_idx) >= packet_len) sel[i] = 8'h00;
    end
    case (transfer_sz)
      2'd1:    rd_word = {16'h0000, sel[0], sel[1]};
      2'd2:    rd_word = {24'h000000, sel[0]};
      default: rd_word = {sel[0], sel[1], sel[2], sel[3]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rd_data <= '0;
      fwd_rd_data <= '0;
    end else begin
      if (cpu_rd_en) cpu_rd_data <= rd_word;
      if (fwd_rd_en)
        fwd_rd_data <= fwd_rd_addr[0] ? bank_odd[fwd_rd_addr[ADDR_WIDTH-1:1]]
                                      : bank_even[fwd_rd_addr[ADDR_WIDTH-1:1]];
    end
  end

endmodule

// File: tb/tb_packetmem_handoff.sv
// tb/tb_packetmem_handoff.sv - randomized self-checking bench for packetmem_handoff
// Reference model: a byte array, a length and an owner (0 snooper, 1 cpu, 2 forwarder).
module tb_packetmem_handoff;

  localparam int AW = 4;
  localparam int TO = 8;
  localparam int NB = 4 * (2 ** AW);

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          wr_en, wr_done;
  logic [2:0]    wr_last_bytes;
  logic          snooper_rdy, mem_ready;
  logic [AW+1:0] cpu_rd_addr;
  logic          cpu_rd_en;
  logic [1:0]    transfer_sz;
  logic [31:0]   cpu_rd_data, packet_len;
  logic          accept, reject, cpu_rst, filter_timeout, fwd_valid;
  logic [AW-1:0] fwd_rd_addr;
  logic          fwd_rd_en;
  logic [31:0]   fwd_rd_data;
  logic          fwd_done;

  packetmem_handoff #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_done(wr_done),
    .wr_last_bytes(wr_last_bytes), .snooper_rdy(snooper_rdy), .mem_ready(mem_ready),
    .cpu_rd_addr(cpu_rd_addr), .cpu_rd_en(cpu_rd_en), .transfer_sz(transfer_sz),
    .cpu_rd_data(cpu_rd_data), .packet_len(packet_len),
    .accept(accept), .reject(reject), .cpu_rst(cpu_rst), .filter_timeout(filter_timeout),
    .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr), .fwd_rd_en(fwd_rd_en),
    .fwd_rd_data(fwd_rd_data), .fwd_done(fwd_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mb [NB];
  int         mlen = 0;
  int         owner = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_rd(input int a, input int sz);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) begin
      int idx = (a + i) % NB;
      b[i] = (idx < mlen) ? mb[idx] : 8'h00;
    end
    if (sz == 1) return {16'h0, b[0], b[1]};
    if (sz == 2) return {24'h0, b[0]};
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic logic [31:0] model_word(input int w);
    return {mb[4*w], mb[4*w+1], mb[4*w+2], mb[4*w+3]};
  endfunction

  task automatic check_owner(input string tag);
    check({tag, "_rdy"}, 32'(snooper_rdy), 32'(owner == 0));
    check({tag, "_memrdy"}, 32'(mem_ready), 32'(owner == 1));
    check({tag, "_fwdv"}, 32'(fwd_valid), 32'(owner == 2));
  endtask

  task automatic write_word(input int addr, input logic [31:0] d, input bit done, input int lb);
    wr_addr = AW'(addr); wr_data = d; wr_en = 1'b1; wr_done = done; wr_last_bytes = 3'(lb);
    tick();
    wr_en = 1'b0; wr_done = 1'b0;
    if (owner == 0) begin
      for (int b = 0; b < 4; b++) mb[4*addr+b] = d[31-8*b -: 8];
      if (done) begin
        mlen  = 4 * addr + ((lb == 0 || lb > 4) ? 4 : lb);
        owner = 1;
      end
    end
  endtask

  task automatic cpu_read(input int a, input int sz, output logic [31:0] got);
    cpu_rd_addr = (AW+2)'(a); transfer_sz = 2'(sz); cpu_rd_en = 1'b1;
    tick();
    cpu_rd_en = 1'b0;
    got = cpu_rd_data;
  endtask

  task automatic fwd_read(input int w, output logic [31:0] got);
    fwd_rd_addr = AW'(w); fwd_rd_en = 1'b1;
    tick();
    fwd_rd_en = 1'b0;
    got = fwd_rd_data;
  endtask

  task automatic verdict(input bit acc, input bit rej);
    accept = acc; reject = rej;
    tick();
    accept = 1'b0; reject = 1'b0;
    if (owner == 1) begin
      if (rej)      owner = 0;
      else if (acc) owner = 2;
    end
  endtask

  task automatic load_directed();
    write_word(0, 32'h01020304, 1'b0, 4);
    write_word(1, 32'h05060708, 1'b0, 4);
    write_word(2, 32'h090A0B0C, 1'b1, 2);
  endtask

  logic [31:0] got;

  initial begin
    rst = 1'b1; wr_addr = '0; wr_data = '0; wr_en = 1'b0; wr_done = 1'b0; wr_last_bytes = '0;
    cpu_rd_addr = '0; cpu_rd_en = 1'b0; transfer_sz = '0; accept = 1'b0; reject = 1'b0;
    fwd_rd_addr = '0; fwd_rd_en = 1'b0; fwd_done = 1'b0;
    for (int i = 0; i < NB; i++) mb[i] = 8'h00;
    tick(); tick();
    rst = 1'b0;

    check_owner("reset");
    check("reset_len", packet_len, 32'd0);
    check("reset_cpu_data", cpu_rd_data, 32'd0);
    check("reset_fwd_data", fwd_rd_data, 32'd0);
    check("reset_timeout", 32'(filter_timeout), 32'd0);
    check("reset_cpu_rst", 32'(cpu_rst), 32'd0);

    // Prime every word so raw forwarder reads are always defined.
    for (int w = 0; w < NB / 4; w++) write_word(w, $urandom, w == NB / 4 - 1, 4);
    check("prime_len", packet_len, 32'(NB));
    verdict(1'b0, 1'b1);
    check_owner("prime_rej");

    load_directed();
    check("dir_len", packet_len, 32'd10);
    check_owner("dir_load");
    cpu_read(1, 2, got); check("dir_b1", got, 32'h00000002);
    cpu_read(3, 1, got); check("dir_h3", got, 32'h00000405);
    cpu_read(5, 0, got); check("dir_w5", got, 32'h06070809);
    cpu_rd_addr = 'd9; tick(); check("dir_hold", cpu_rd_data, 32'h06070809);
    cpu_read(8, 0, got); check("dir_w8", got, 32'h090A0000);
    verdict(1'b1, 1'b0);
    check_owner("dir_acc");
    fwd_read(1, got); check("dir_fwd1", got, 32'h05060708);
    write_word(1, 32'hDEADBEEF, 1'b0, 4);
    fwd_read(1, got); check("dir_fwd_wr_ignored", got, 32'h05060708);
    cpu_read(4, 3, got); check("dir_rd_in_fwd", got, 32'h05060708);
    fwd_done = 1'b1; tick(); fwd_done = 1'b0; owner = 0;
    check_owner("dir_fwd_done");

    load_directed();
    write_word(0, 32'hDEADBEEF, 1'b1, 4);
    check("filt_wr_len", packet_len, 32'd10);
    cpu_read(0, 0, got); check("filt_wr_ignored", got, 32'h01020304);
    verdict(1'b0, 1'b1);
    check_owner("dir_rej");
    load_directed();
    verdict(1'b1, 1'b1);
    check_owner("dir_both");

    // Watchdog with no verdict: count FILTER cycles up to the forced exit.
    load_directed();
    begin
      int n = 0;
      bit seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        if (mem_ready) n++;
        else if (snooper_rdy) begin
          seen = 1'b1;
          check("to_pulse", 32'(filter_timeout), 32'd1);
          check("to_cpu_rst", 32'(cpu_rst), 32'd1);
        end
        if (!seen) tick();
      end
      check("to_seen", 32'(seen), 32'd1);
      check("to_cycles", 32'(n), 32'(TO));
      tick();
      check("to_pulse_end", 32'(filter_timeout), 32'd0);
      check("to_cpu_rst_end", 32'(cpu_rst), 32'd0);
      owner = 0;
    end

    for (int k = 0; k < 2; k++) begin
      load_directed();
      for (int c = 1; c < TO; c++) tick();
      check("to_last_cycle", 32'(mem_ready), 32'd1);
      verdict(k == 0, k == 1);
      check_owner("to_verdict");
      check("to_verdict_pulse", 32'(filter_timeout), 32'd0);
      check("to_verdict_cpu_rst", 32'(cpu_rst), 32'd0);
      if (owner == 2) begin
        fwd_done = 1'b1; tick(); fwd_done = 1'b0; owner = 0;
      end
    end

    load_directed();
    verdict(1'b1, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    owner = 0; mlen = 0;
    check_owner("rst_fwd");
    check("rst_len", packet_len, 32'd0);
    cpu_read(0, 0, got); check("rst_rd_zero", got, 32'd0);

    for (int p = 0; p < 30; p++) begin
      int nw = $urandom_range(1, NB / 4);
      for (int w = 0; w < nw; w++) begin
        if ($urandom_range(0, 3) == 0) begin
          wr_addr = AW'($urandom); wr_done = 1'b1; wr_en = 1'b0;
          tick();
          wr_done = 1'b0;
        end
        write_word(w, $urandom, w == nw - 1, $urandom_range(0, 7));
      end
      check("rnd_len", packet_len, 32'(mlen));
      check_owner("rnd_load");
      write_word($urandom_range(0, NB / 4 - 1), $urandom, 1'b1, 4);
      for (int r = 0; r < $urandom_range(1, 5); r++) begin
        int a = $urandom_range(0, NB - 1);
        int sz = $urandom_range(0, 3);
        cpu_read(a, sz, got); check("rnd_cpu_rd", got, model_rd(a, sz));
      end
      verdict($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
      check_owner("rnd_verdict");
      if (owner == 1) verdict(1'b0, 1'b1);
      if (owner == 2) begin
        write_word($urandom_range(0, NB / 4 - 1), $urandom, 1'b0, 4);
        for (int r = 0; r < 3; r++) begin
          int w = $urandom_range(0, NB / 4 - 1);
          fwd_read(w, got); check("rnd_fwd_rd", got, model_word(w));
        end
        fwd_done = 1'b1; tick(); fwd_done = 1'b0; owner = 0;
        check_owner("rnd_fwd_done");
      end
      for (int r = 0; r < 2; r++) begin
        int a = $urandom_range(0, NB - 1);
        int sz = $urandom_range(0, 3);
        cpu_read(a, sz, got); check("rnd_fill_rd", got, model_rd(a, sz));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
